// File: rtl/shift_issue_unit.sv
// ----------------------------------------------------------------------------
// shift_issue_unit
//
// Issues one decoded shift operation at a time to an external combinational
// shifter. Each op passes through four phases: accept (IDLE), register-file
// read (READ), shift (SHIFT) and write-back handshake (WB). Only one op is
// ever in flight, so the best case is one op every four cycles.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   flush                 synchronous abort, returns to IDLE and drops the op
//   in_valid / in_ready   op offer / accept handshake (ready only in IDLE)
//   in_op                 {var, kind[1:0]}: 00 sll, 01 srl, 10 sra, 11 illegal
//   in_rs, in_rt          source/destination reg, shift-amount reg
//   in_shamt              immediate shift amount (var = 0)
//   rf_raddr1/2           register-file read addresses (driven in READ only)
//   rf_rdata1/2           register-file read data (combinational read)
//   sh_A, sh_shamt,       shifter operand, amount, direction (1 = right)
//   sh_drxn, sh_type      and type (1 = arithmetic); driven in SHIFT only
//   sh_out                combinational shifter result
//   wb_valid / wb_ready   write-back handshake
//   wb_addr, wb_data      destination register and result (driven in WB only)
//   err                   one-cycle pulse in the SHIFT cycle of an illegal op
// ----------------------------------------------------------------------------
module shift_issue_unit #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [4:0]        in_shamt,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic [DATA_W-1:0] sh_A,
   output logic [4:0]        sh_shamt,
   output logic              sh_drxn,
   output logic              sh_type,
   input  logic [DATA_W-1:0] sh_out,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      SHIFT = 2'd2,
      WB    = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic              op_var;
   logic [1:0]        op_kind;
   logic [REG_AW-1:0] cap_rs;
   logic [REG_AW-1:0] cap_rt;
   logic [4:0]        cap_shamt;
   logic [DATA_W-1:0] opnd_a;
   logic [4:0]        amt;
   logic [DATA_W-1:0] result;
   logic              accept;
   logic              illegal;

   // Only the low five bits of a register shift amount matter; the rest of
   // the read word is deliberately discarded.
   logic unused_rdata2_hi;
   assign unused_rdata2_hi = ^rf_rdata2[DATA_W-1:5];

   // Flush wins over an offered op, so nothing is captured on a flush edge.
   assign accept  = (state == IDLE) && in_valid && !flush;
   assign illegal = (op_kind == 2'b11);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. All outputs default to zero so that every
   // interface is quiet outside the phase that owns it. The flush override
   // is applied last so it beats both an accept and a write-back handshake.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      rf_raddr1  = '0;
      rf_raddr2  = '0;
      sh_A       = '0;
      sh_shamt   = '0;
      sh_drxn    = 1'b0;
      sh_type    = 1'b0;
      wb_valid   = 1'b0;
      wb_addr    = '0;
      wb_data    = '0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) state_next = READ;
         end
         READ: begin
            rf_raddr1  = cap_rs;
            rf_raddr2  = cap_rt;
            state_next = SHIFT;
         end
         SHIFT: begin
            if (illegal) begin
               err = 1'b1;
            end else begin
               sh_A     = opnd_a;
               sh_shamt = amt;
               sh_drxn  = (op_kind != 2'b00);
               sh_type  = (op_kind == 2'b10);
            end
            state_next = WB;
         end
         WB: begin
            wb_valid = 1'b1;
            wb_addr  = cap_rs;
            wb_data  = result;
            if (wb_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Datapath captures: op fields on accept, operands in READ, the result in
   // SHIFT. An illegal op bypasses the shifter and writes its operand back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_var    <= 1'b0;
         op_kind   <= 2'b00;
         cap_rs    <= '0;
         cap_rt    <= '0;
         cap_shamt <= '0;
         opnd_a    <= '0;
         amt       <= '0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_var    <= in_op[2];
                  op_kind   <= in_op[1:0];
                  cap_rs    <= in_rs;
                  cap_rt    <= in_rt;
                  cap_shamt <= in_shamt;
               end
            end
            READ: begin
               opnd_a <= rf_rdata1;
               amt    <= op_var ? rf_rdata2[4:0] : cap_shamt;
            end
            SHIFT: begin
               result <= illegal ? opnd_a : sh_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_issue_unit.sv
// ----------------------------------------------------------------------------
// tb_shift_issue_unit
//
// Drives directed shift ops into shift_issue_unit with a behavioural register
// file and shifter around it. Expected write-backs are queued as ops are
// issued; a monitor pops and compares on every completed write-back.
// ----------------------------------------------------------------------------
module tb_shift_issue_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_shamt;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [31:0] sh_A;
   logic [4:0]  sh_shamt;
   logic        sh_drxn;
   logic        sh_type;
   logic [31:0] sh_out;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        err;

   logic [31:0] rf [32];
   logic [36:0] exp_q [$];
   int          checks;
   int          errors;
   int          wb_count;

   shift_issue_unit #(.DATA_W(32), .REG_AW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_shamt  (in_shamt),
      .rf_raddr1 (rf_raddr1),
      .rf_raddr2 (rf_raddr2),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .sh_A      (sh_A),
      .sh_shamt  (sh_shamt),
      .sh_drxn   (sh_drxn),
      .sh_type   (sh_type),
      .sh_out    (sh_out),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .err       (err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational register file.
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   // Behavioural shifter; arithmetic shift kept in its own branch so the
   // signed shift is not demoted to unsigned by a mixed expression.
   always_comb begin
      sh_out = sh_A << sh_shamt;
      if (sh_drxn) begin
         if (sh_type) sh_out = $signed(sh_A) >>> sh_shamt;
         else         sh_out = sh_A >> sh_shamt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Waits (bounded) for in_ready, offers the op for one edge, then drops
   // in_valid. Returns just after the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] shamt);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1");
      end
      in_valid = 1'b1;
      in_op    = op;
      in_rs    = rs;
      in_rt    = rt;
      in_shamt = shamt;
      tick();
      in_valid = 1'b0;
   endtask

   // Scoreboard monitor: a write-back completes when valid and ready are
   // both high at an edge without flush or reset.
   always @(negedge clk) begin
      if (rst && !flush && wb_valid && wb_ready) begin
         logic [36:0] e;
         wb_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_wb: got addr %0d data 0x%08h expected none",
                     wb_addr, wb_data);
         end else begin
            e = exp_q.pop_front();
            if (wb_addr !== e[36:32] || wb_data !== e[31:0]) begin
               errors++;
               $display("[TB] FAIL wb_result: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                        wb_addr, wb_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      wb_count = 0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[2] = 32'hFFFF_0000;
      rf[3] = 32'h0000_00F1;
      rf[5] = 32'h8000_0000;
      rf[6] = 32'h0000_0021;
      rf[7] = 32'h1234_5678;
      rst      = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_op    = 3'b000;
      in_rs    = 5'd0;
      in_rt    = 5'd0;
      in_shamt = 5'd0;
      wb_ready = 1'b1;

      // Reset state.
      #12;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_wb_addr", 32'(wb_addr), 32'd0);
      checkOutput("rst_wb_data", wb_data, 32'd0);
      checkOutput("rst_raddr1", 32'(rf_raddr1), 32'd0);
      checkOutput("rst_sh_A", sh_A, 32'd0);
      rst = 1'b1;
      tick();

      // Immediate sll R3 by 4, with latency checks.
      exp_q.push_back({5'd3, 32'h0000_0F10});
      applyStimulus(3'b000, 5'd3, 5'd0, 5'd4);
      checkOutput("read_in_ready", 32'(in_ready), 32'd0);
      checkOutput("read_raddr1", 32'(rf_raddr1), 32'd3);
      checkOutput("read_sh_A", sh_A, 32'd0);
      tick();
      checkOutput("sll_sh_A", sh_A, 32'h0000_00F1);
      checkOutput("sll_sh_shamt", 32'(sh_shamt), 32'd4);
      checkOutput("sll_sh_drxn", 32'(sh_drxn), 32'd0);
      checkOutput("sll_wb_valid_early", 32'(wb_valid), 32'd0);
      checkOutput("sll_raddr1_idle", 32'(rf_raddr1), 32'd0);
      tick();
      checkOutput("sll_wb_valid_e2", 32'(wb_valid), 32'd1);
      checkOutput("sll_sh_A_wb", sh_A, 32'd0);
      tick();
      checkOutput("sll_idle_e3", 32'(in_ready), 32'd1);
      checkOutput("sll_wb_valid_e3", 32'(wb_valid), 32'd0);

      // Variable sra: R6 = 33, only the low five bits count.
      exp_q.push_back({5'd5, 32'hC000_0000});
      applyStimulus(3'b110, 5'd5, 5'd6, 5'd0);
      checkOutput("sra_raddr2", 32'(rf_raddr2), 32'd6);
      tick();
      checkOutput("sra_sh_shamt", 32'(sh_shamt), 32'd1);
      checkOutput("sra_sh_drxn", 32'(sh_drxn), 32'd1);
      checkOutput("sra_sh_type", 32'(sh_type), 32'd1);
      tick();
      tick();

      // srl by 16 with write-back stalled for five cycles.
      wb_ready = 1'b0;
      exp_q.push_back({5'd2, 32'h0000_FFFF});
      applyStimulus(3'b001, 5'd2, 5'd0, 5'd16);
      tick();
      checkOutput("srl_sh_type", 32'(sh_type), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("srl_hold_valid", 32'(wb_valid), 32'd1);
         checkOutput("srl_hold_data", wb_data, 32'h0000_FFFF);
         checkOutput("srl_hold_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      wb_ready = 1'b1;
      tick();
      checkOutput("srl_done_valid", 32'(wb_valid), 32'd0);
      checkOutput("srl_done_in_ready", 32'(in_ready), 32'd1);

      // Illegal kind: err pulse in SHIFT only, operand written back as-is.
      exp_q.push_back({5'd7, 32'h1234_5678});
      applyStimulus(3'b011, 5'd7, 5'd0, 5'd9);
      checkOutput("ill_err_read", 32'(err), 32'd0);
      tick();
      checkOutput("ill_err_shift", 32'(err), 32'd1);
      tick();
      checkOutput("ill_err_wb", 32'(err), 32'd0);
      tick();

      // Flush in SHIFT with a new op offered the same cycle.
      applyStimulus(3'b000, 5'd3, 5'd0, 5'd1);
      tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = 3'b001;
      in_rs    = 5'd2;
      in_rt    = 5'd0;
      in_shamt = 5'd4;
      tick();
      flush = 1'b0;
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
      checkOutput("flush_wb_valid", 32'(wb_valid), 32'd0);
      exp_q.push_back({5'd2, 32'h0FFF_F000});
      tick();
      in_valid = 1'b0;
      checkOutput("flush_accept_next", 32'(in_ready), 32'd0);
      tick();
      tick();
      tick();

      // Reset while stalled in WB.
      wb_ready = 1'b0;
      applyStimulus(3'b000, 5'd3, 5'd0, 5'd4);
      tick();
      tick();
      checkOutput("rstwb_valid_before", 32'(wb_valid), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("rstwb_valid_now", 32'(wb_valid), 32'd0);
      checkOutput("rstwb_in_ready", 32'(in_ready), 32'd1);
      #5;
      rst      = 1'b1;
      wb_ready = 1'b1;
      exp_q.push_back({5'd3, 32'h0000_0F10});
      in_valid = 1'b1;
      in_op    = 3'b000;
      in_rs    = 5'd3;
      in_rt    = 5'd0;
      in_shamt = 5'd4;
      tick();
      in_valid = 1'b0;
      checkOutput("post_rst_accept", 32'(in_ready), 32'd0);
      tick();
      tick();
      tick();
      checkOutput("post_rst_idle", 32'(in_ready), 32'd1);

      tick();
      checkOutput("wb_count", 32'(wb_count), 32'd6);
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
